// File: rtl/src_seq_pkg.sv
// Shared types and constants for the source operand sequencer (src_operand_seq).
// Optional LFSR support is controlled by SRC_OPERAND_SEQ_LFSR_EN in the top module.
package src_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int VEC_W  = 4;
  localparam int LFSR_W = 8;

  // Fibonacci feedback taps; the register shifts left and the XOR enters bit 0.
  localparam int LFSR_TAP0 = 7;
  localparam int LFSR_TAP1 = 5;
  localparam int LFSR_TAP2 = 4;
  localparam int LFSR_TAP3 = 3;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
  endfunction

endpackage

// File: rtl/src_seq_lfsr.sv
// 8-bit load/advance LFSR supplying the operand vector in LFSR mode.
// Only instantiated when SRC_OPERAND_SEQ_LFSR_EN is defined; a zero seed is replaced by 8'h01.
module src_seq_lfsr
  import src_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_adv,
  output logic [VEC_W-1:0] o_vec
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= SEED_EFF;
    end else if (i_adv) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_vec = r_lfsr[VEC_W-1:0];

endmodule

// File: rtl/src_operand_seq.sv
// Bounded operand-vector generator (exhaustive count or LFSR) with per-vector hold and ones counter.
// LFSR mode is built only when SRC_OPERAND_SEQ_LFSR_EN is defined; otherwise mode is ignored.
module src_operand_seq
  import src_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC   = 16,
  parameter int unsigned HOLD      = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        data_out,
  output logic [1:0]  data_inA,
  output logic [1:0]  data_inB,
  output logic        vec_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_idx,
  output logic [15:0] ones_cnt
);

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);
  localparam logic [15:0] VEC_LAST  = 16'(NUM_VEC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_hold;
  logic [15:0]       r_vec_idx;
  logic [15:0]       r_ones;
  logic              w_last_hold;
  logic              w_last_vec;
  logic              w_start_acc;
  logic              w_advance;
  logic [VEC_W-1:0]  w_vec;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_last_hold = (r_hold == HOLD_LAST);
  assign w_last_vec  = (r_vec_idx == VEC_LAST);
  assign w_advance   = (r_state == DRIVE) && w_last_hold && !w_last_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = DRIVE;
      DRIVE:   if (w_last_hold && w_last_vec) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hold counter is left at HOLD-1 after the final vector; the next start clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_vec_idx <= '0;
      r_ones    <= '0;
    end else if (w_start_acc) begin
      r_hold    <= '0;
      r_vec_idx <= '0;
      r_ones    <= '0;
    end else if (r_state == DRIVE) begin
      if (w_last_hold) begin
        if (data_out && (r_ones != CNT_SAT)) r_ones <= r_ones + 16'd1;
        if (!w_last_vec) begin
          r_vec_idx <= r_vec_idx + 16'd1;
          r_hold    <= '0;
        end
      end else begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

`ifdef SRC_OPERAND_SEQ_LFSR_EN
  logic             r_mode;
  logic [VEC_W-1:0] w_lfsr_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_start_acc) begin
      r_mode <= mode;
    end
  end

  src_seq_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_acc),
    .i_adv  (w_advance),
    .o_vec  (w_lfsr_vec)
  );

  assign w_vec = r_mode ? w_lfsr_vec : r_vec_idx[VEC_W-1:0];
`else
  logic w_unused;
  assign w_unused = ^{mode, LFSR_SEED, w_advance};
  assign w_vec    = r_vec_idx[VEC_W-1:0];
`endif

  always_comb begin
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    data_inA  = 2'b00;
    data_inB  = 2'b00;
    unique case (r_state)
      DRIVE: begin
        vec_valid = 1'b1;
        busy      = 1'b1;
        data_inA  = w_vec[3:2];
        data_inB  = w_vec[1:0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign vec_idx  = r_vec_idx;
  assign ones_cnt = r_ones;

endmodule

// File: tb/tb_src_operand_seq.sv
// Directed bench for src_operand_seq: exhaustive runs, hold, restart rules, reset and mode=1
// (LFSR vectors when SRC_OPERAND_SEQ_LFSR_EN is defined, exhaustive otherwise).
module tb_src_operand_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        s1_start = 1'b0, s1_mode = 1'b0, s1_dout, d1_sel = 1'b0;
  logic [1:0]  a1, b1;
  logic        vv1, busy1, done1;
  logic [15:0] idx1, ones1;

  logic        s3_start = 1'b0, s3_mode = 1'b0, s3_dout;
  logic [1:0]  a3, b3;
  logic        vv3, busy3, done3;
  logic [15:0] idx3, ones3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Downstream stand-ins: constant 1 or data_inA[0] for the 16-vector unit, data_inB[0] for the hold unit.
  assign s1_dout = d1_sel ? a1[0] : 1'b1;
  assign s3_dout = b3[0];

  src_operand_seq #(.NUM_VEC(16), .HOLD(1), .LFSR_SEED(8'hA5)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .mode(s1_mode), .data_out(s1_dout),
    .data_inA(a1), .data_inB(b1), .vec_valid(vv1), .busy(busy1), .done(done1),
    .vec_idx(idx1), .ones_cnt(ones1)
  );

  src_operand_seq #(.NUM_VEC(4), .HOLD(3), .LFSR_SEED(8'hA5)) u3 (
    .clk(clk), .rst(rst), .start(s3_start), .mode(s3_mode), .data_out(s3_dout),
    .data_inA(a3), .data_inB(b3), .vec_valid(vv3), .busy(busy3), .done(done3),
    .vec_idx(idx3), .ones_cnt(ones3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({vv1, busy1, done1, a1, b1, idx1, ones1} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_u1 got=%h exp=0", {vv1, busy1, done1, a1, b1, idx1, ones1});
    end
    n_tests++;
    if ({vv3, busy3, done3, a3, b3, idx3, ones3} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_u3 got=%h exp=0", {vv3, busy3, done3, a3, b3, idx3, ones3});
    end
    rst = 1'b0;
    tick();
  endtask

  // Start at edge 0; vectors after edges 1..16, done after edge 17.
  task automatic test_exhaustive(input logic sel, input logic [15:0] exp_ones, input string nm);
    logic [15:0] kv;
    d1_sel = sel;
    s1_mode = 1'b0;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      kv = 16'(k);
      n_tests++;
      if ({vv1, busy1, done1, a1, b1, idx1} !== {3'b110, kv[3:0], kv}) begin
        n_fail++;
        $display("FAIL %s_vec%0d got=%h exp=%h", nm, k, {vv1, busy1, done1, a1, b1, idx1},
                 {3'b110, kv[3:0], kv});
      end
      tick();
    end
    n_tests++;
    if ({vv1, busy1, done1, ones1} !== {3'b001, exp_ones}) begin
      n_fail++;
      $display("FAIL %s_done got=%h exp=%h", nm, {vv1, busy1, done1, ones1}, {3'b001, exp_ones});
    end
    tick();
    n_tests++;
    if ({vv1, busy1, done1, ones1} !== {3'b000, exp_ones}) begin
      n_fail++;
      $display("FAIL %s_idle got=%h exp=%h", nm, {vv1, busy1, done1, ones1}, {3'b000, exp_ones});
    end
  endtask

  task automatic test_mode1();
    logic [3:0] exp_vec [16];
    int         n_chk;
    logic [15:0] kv;
`ifdef SRC_OPERAND_SEQ_LFSR_EN
    // Seed A5 -> 4A -> 95 -> 2A -> 54 -> A9; vector is the low nibble.
    exp_vec = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h4, 4'h9, 4'h0, 4'h0,
                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    n_chk = 6;
`else
    for (int k = 0; k < 16; k++) exp_vec[k] = 4'(k);
    n_chk = 16;
`endif
    d1_sel = 1'b0;
    s1_mode = 1'b1;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    s1_mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      kv = 16'(k);
      if (k < n_chk) begin
        n_tests++;
        if ({vv1, busy1, done1, a1, b1, idx1} !== {3'b110, exp_vec[k], kv}) begin
          n_fail++;
          $display("FAIL mode1_vec%0d got=%h exp=%h", k, {vv1, busy1, done1, a1, b1, idx1},
                   {3'b110, exp_vec[k], kv});
        end
      end
      tick();
    end
    n_tests++;
    if ({vv1, busy1, done1, ones1} !== {3'b001, 16'd16}) begin
      n_fail++;
      $display("FAIL mode1_done got=%h exp=%h", {vv1, busy1, done1, ones1}, {3'b001, 16'd16});
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    d1_sel = 1'b0;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({vv1, busy1, done1, a1, b1, idx1, ones1} !== 39'd0) begin
      n_fail++;
      $display("FAIL midrun_rst got=%h exp=0", {vv1, busy1, done1, a1, b1, idx1, ones1});
    end
    rst = 1'b0;
    tick();
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    n_tests++;
    if ({vv1, busy1, idx1, ones1} !== {2'b11, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL rerun_first got=%h exp=%h", {vv1, busy1, idx1, ones1}, {2'b11, 32'd0});
    end
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if ({busy1, idx1} !== {1'b1, 16'd15}) begin
      n_fail++;
      $display("FAIL rerun_last got=%h exp=%h", {busy1, idx1}, {1'b1, 16'd15});
    end
    tick();
    n_tests++;
    if ({busy1, done1, ones1} !== {2'b01, 16'd16}) begin
      n_fail++;
      $display("FAIL rerun_done got=%h exp=%h", {busy1, done1, ones1}, {2'b01, 16'd16});
    end
    tick();
  endtask

  // HOLD=3, NUM_VEC=4: vector k after edges 3k+1..3k+3, done after edge 13; stray start at cycle 5.
  task automatic test_hold3();
    logic [15:0] kv;
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      kv = 16'((e - 1) / 3);
      n_tests++;
      if ({vv3, busy3, done3, a3, b3, idx3} !== {3'b110, kv[3:0], kv}) begin
        n_fail++;
        $display("FAIL hold3_e%0d got=%h exp=%h", e, {vv3, busy3, done3, a3, b3, idx3},
                 {3'b110, kv[3:0], kv});
      end
      if (e == 4) s3_start = 1'b1;
      if (e == 5) s3_start = 1'b0;
      tick();
    end
    n_tests++;
    if ({vv3, busy3, done3, ones3} !== {3'b001, 16'd2}) begin
      n_fail++;
      $display("FAIL hold3_done got=%h exp=%h", {vv3, busy3, done3, ones3}, {3'b001, 16'd2});
    end
  endtask

  // Entered in the done cycle of the previous run: start there is ignored, the next cycle's is taken.
  task automatic test_back_to_back();
    s3_start = 1'b1;
    tick();
    n_tests++;
    if ({vv3, busy3, done3, ones3} !== {3'b000, 16'd2}) begin
      n_fail++;
      $display("FAIL b2b_ignored got=%h exp=%h", {vv3, busy3, done3, ones3}, {3'b000, 16'd2});
    end
    tick();
    s3_start = 1'b0;
    n_tests++;
    if ({vv3, busy3, a3, b3, idx3, ones3} !== {2'b11, 4'h0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL b2b_accept got=%h exp=%h", {vv3, busy3, a3, b3, idx3, ones3},
               {2'b11, 36'd0});
    end
    for (int i = 0; i < 12; i++) tick();
    n_tests++;
    if ({busy3, done3, ones3} !== {2'b01, 16'd2}) begin
      n_fail++;
      $display("FAIL b2b_done got=%h exp=%h", {busy3, done3, ones3}, {2'b01, 16'd2});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_exhaustive(1'b0, 16'd16, "exh_ones");
    test_exhaustive(1'b1, 16'd8, "exh_ina");
    test_hold3();
    test_back_to_back();
    test_mode1();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/src_operand_seq.md
# src_operand_seq

Sequential operand generator that sits directly upstream of the source datapath stage (2-bit operand pair in, 1-bit `data_out` back). It drives `data_inA`/`data_inB` with a bounded run of vectors, either an exhaustive count or an LFSR sequence, and holds each vector for a programmable number of cycles. It samples the returned `data_out` at the end of each vector and counts the ones. It replaces the free-running testbench registers as the activity source for power and property characterisation runs.

## Interface
- `NUM_VEC`, 16: vectors per run; legal range 1..65535.
- `HOLD`, 1: cycles each vector is held; legal range 1..255.
- `LFSR_SEED`, 8'hA5: LFSR load value on start; a seed of 0 is replaced by 8'h01.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `mode`  in  1  0 = exhaustive count, 1 = LFSR; sampled with `start`.
- `data_out`  in  1  result returned by the downstream stage (combinational on the current vector).
- `data_inA`  out  2  operand A = vector[3:2].
- `data_inB`  out  2  operand B = vector[1:0].
- `vec_valid`  out  1  high while a vector is driven.
- `busy`  out  1  high in DRIVE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `vec_idx`  out  16  index of the current vector.
- `ones_cnt`  out  16  count of vectors whose sampled `data_out` was 1; holds its value until the next start.

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE**
  - `data_inA`, `data_inB`, `vec_valid`, `busy` are 0.
  - On `start`: latch `mode`, clear `vec_idx`, `ones_cnt` and the hold counter, load the LFSR with the seed, go to DRIVE.
- **DRIVE**
  - Drive the 4-bit vector; hold counter counts 0..HOLD-1.
  - On the last hold cycle: `ones_cnt` += `data_out`, saturating at 16'hFFFF.
  - On the last hold cycle with `vec_idx` == NUM_VEC-1: go to DONE.
  - Otherwise on the last hold cycle: advance `vec_idx` and the LFSR, and reset the hold counter.
- **DONE**
  - `done` = 1 for one cycle; `vec_valid` = 0; return to IDLE.
- Exhaustive mode: vector = `vec_idx`[3:0]; wraps mod 16 when NUM_VEC > 16.
- LFSR mode:
  - 8-bit Fibonacci, left shift; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - vector = lfsr[3:0].
- `start` while in DRIVE or DONE is ignored; a run is never restarted.
- `rst` in any state: the next edge returns to IDLE; all outputs and counters become 0, including `ones_cnt`.

## Timing
- Reset values: every output is 0.
- `start` high at edge N → `busy`, `vec_valid` and the first vector valid from edge N+1.
- Vector k is driven during cycles N+1+k·HOLD .. N+(k+1)·HOLD.
- `data_out` is sampled at the edge ending each vector.
- `done` is high for the single cycle after edge N+NUM_VEC·HOLD+1.
- `busy` falls in that same cycle.
- `ones_cnt` is final when `done` is high.
- Earliest back-to-back: `start` asserted during the `done` cycle is ignored; the first accepted restart is the cycle after.

## Configuration
- `SRC_OPERAND_SEQ_LFSR_EN` defined: LFSR register and `mode` = 1 supported as described.
- Not defined:
  - No LFSR logic is built; `mode` is ignored; the block always runs exhaustive.
  - `LFSR_SEED` is unused.

## Structure
- Shared package `src_seq_pkg`:
  - state enum (IDLE/DRIVE/DONE)
  - vector width constant (4)
  - LFSR width (8) and tap positions
  - saturation constant 16'hFFFF
- One sub-module, `src_seq_lfsr`: 8-bit load/advance LFSR, instantiated only under `SRC_OPERAND_SEQ_LFSR_EN`.
- FSM, hold counter and result counter stay in the top module.

## Test plan
1. Exhaustive, NUM_VEC=16, HOLD=1, `data_out` tied 1, `start` at edge 0:
   - Vectors 0..15 on cycles 1..16.
   - `done` in the cycle after edge 17.
   - `ones_cnt` = 16.
2. Exhaustive, NUM_VEC=16, `data_out` = `data_inA`[0] via bench model → `ones_cnt` = 8.
3. HOLD=3, NUM_VEC=4:
   - Each vector is stable for exactly 3 cycles.
   - `done` in the cycle after edge 13.
   - A `start` pulse at cycle 5 has no effect.
4. LFSR mode (macro defined), seed 8'hA5:
   - Vectors are 4'h5, 4'hA, 4'h5, i.e. (A,B) = (01,01), (10,10), (01,01).
   - Next LFSR states are 8'h4A and 8'h95.
5. `rst` asserted at cycle 6 of a 16-vector run:
   - All outputs are 0 after the next edge, `ones_cnt` = 0.
   - A new `start` runs the full 16 vectors.
6. Macro undefined, `mode` = 1 → output identical to scenario 1.
